// File: rtl/dir_arbiter_n.sv
// Debounced, dead-time-protected one-hot direction latch for a DC motor driver; dir follows a held request DEB_CYCLES+3 edges later.
// Optional REVERSAL_COUNT_EN adds a saturating count of completed direction reversals (rev_count).
module dir_arbiter_n #(
    parameter int CH          = 2,
    parameter int DEB_CYCLES  = 3,
    parameter int DEAD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] req,
    input  logic          stop,
    output logic [CH-1:0] dir,
    output logic          busy
`ifdef REVERSAL_COUNT_EN
    ,
    output logic [15:0]   rev_count
`endif
);

    localparam int DBW = $clog2(DEB_CYCLES) + 1;
    localparam int DDW = $clog2(DEAD_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } state_e;

    logic [CH-1:0]  sync1_q;
    logic [CH-1:0]  sync2_q;
    logic [CH-1:0]  deb_q;
    logic [CH-1:0]  deb_d;
    logic [DBW-1:0] deb_cnt_q [CH];
    logic [DBW-1:0] deb_cnt_d [CH];

    state_e         state_q;
    state_e         state_d;
    logic [CH-1:0]  dir_q;
    logic [CH-1:0]  dir_d;
    logic           busy_q;
    logic           busy_d;
    logic [CH-1:0]  target_q;
    logic [CH-1:0]  target_d;
    logic [DDW-1:0] dead_cnt_q;
    logic [DDW-1:0] dead_cnt_d;
    logic [CH-1:0]  others;

    // Lowest-index set bit as a one-hot vector (all-zero if none set).
    function automatic logic [CH-1:0] lowest_set(input logic [CH-1:0] v);
        logic [CH-1:0] r;
        r = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    // A level is accepted on the edge where the mismatch count would reach DEB_CYCLES.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < CH; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DBW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < CH; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < CH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // In DRIVE, dir_q is the one-hot of the active channel.
    assign others = deb_q & ~dir_q;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        busy_d     = busy_q;
        target_d   = target_q;
        dead_cnt_d = dead_cnt_q;
        if (stop) begin
            state_d    = ST_IDLE;
            dir_d      = '0;
            busy_d     = 1'b0;
            dead_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dir_d  = '0;
                    busy_d = 1'b0;
                    if (|deb_q) begin
                        state_d = ST_DRIVE;
                        dir_d   = lowest_set(deb_q);
                    end
                end
                ST_DRIVE: begin
                    busy_d = 1'b0;
                    if (!(|(deb_q & dir_q)) && (|others)) begin
                        state_d    = ST_DEAD;
                        target_d   = lowest_set(others);
                        dir_d      = '0;
                        busy_d     = 1'b1;
                        dead_cnt_d = DDW'(DEAD_CYCLES);
                    end
                end
                ST_DEAD: begin
                    dir_d  = '0;
                    busy_d = 1'b1;
                    if (dead_cnt_q <= DDW'(1)) begin
                        state_d    = ST_DRIVE;
                        dir_d      = target_q;
                        busy_d     = 1'b0;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q - DDW'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    dir_d      = '0;
                    busy_d     = 1'b0;
                    dead_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= '0;
            busy_q     <= 1'b0;
            target_q   <= '0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            target_q   <= target_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign dir  = dir_q;
    assign busy = busy_q;

`ifdef REVERSAL_COUNT_EN
    logic [15:0] rev_q;
    logic [15:0] rev_d;

    // Only a completed dead-time expiry counts; stop forces IDLE so it never counts.
    always_comb begin
        rev_d = rev_q;
        if (state_q == ST_DEAD && state_d == ST_DRIVE && rev_q != 16'hFFFF) begin
            rev_d = rev_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_q <= '0;
        end else begin
            rev_q <= rev_d;
        end
    end

    assign rev_count = rev_q;
`endif

endmodule
